// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dm_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int STAT_W     = 16;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef logic port_idx_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dm_arbiter_rr_pick2.sv
// rtl/dm_arbiter_rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  last,
    output port_idx_t  winner,
    output logic       any
);

    always_comb begin
        any = |req;
        // On a tie the port that did not win last time goes next.
        if (req == 2'b11) begin
            winner = ~last;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin share of one data memory between CPU and loader ports
// Optional grant/conflict statistics outputs enabled by DM_ARB_STATS_EN.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
`ifdef DM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] p0_cnt,
    output logic [STAT_W-1:0] p1_cnt,
    output logic [STAT_W-1:0] conflict_cnt
`endif
);

    state_t    state;
    state_t    state_d;
    port_idx_t last;
    port_idx_t win_r;
    port_idx_t winner;
    logic      any;
    logic      issue;

    rr_pick2 u_pick (
        .req    ({p1_req, p0_req}),
        .last   (last),
        .winner (winner),
        .any    (any)
    );

    assign issue = (state == IDLE) && any;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (any) state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and grants are registered so the memory sees exactly one falling edge per access.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            last        <= 1'b1;
            win_r       <= 1'b0;
            p0_gnt      <= 1'b0;
            p1_gnt      <= 1'b0;
            p0_rvalid   <= 1'b0;
            p1_rvalid   <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
        end else begin
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            mem_rden  <= 1'b0;
            mem_wren  <= 1'b0;
            if (state == ACCESS && mem_rden) begin
                if (win_r) begin
                    p1_rdata  <= mem_q;
                    p1_rvalid <= 1'b1;
                end else begin
                    p0_rdata  <= mem_q;
                    p0_rvalid <= 1'b1;
                end
            end
            if (issue) begin
                last        <= winner;
                win_r       <= winner;
                p0_gnt      <= ~winner;
                p1_gnt      <= winner;
                mem_address <= winner ? p1_addr  : p0_addr;
                mem_data    <= winner ? p1_wdata : p0_wdata;
                mem_wren    <= winner ? p1_we    : p0_we;
                mem_rden    <= winner ? ~p1_we   : ~p0_we;
            end
        end
    end

`ifdef DM_ARB_STATS_EN
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            p0_cnt       <= '0;
            p1_cnt       <= '0;
            conflict_cnt <= '0;
        end else begin
            if (issue && !winner) p0_cnt <= sat_inc(p0_cnt);
            if (issue && winner)  p1_cnt <= sat_inc(p1_cnt);
            if (state == IDLE && p0_req && p1_req) conflict_cnt <= sat_inc(conflict_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed self-checking bench for dm_arbiter
module tb_dm_arbiter;

    logic        clock = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [7:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [7:0]  mem_address;
    logic [31:0] mem_data;
    logic        mem_rden, mem_wren;
    logic [31:0] mem_q = 32'h0;
    logic [31:0] mem [0:255];
`ifdef DM_ARB_STATS_EN
    logic [15:0] p0_cnt, p1_cnt, conflict_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    dm_arbiter dut (
        .clock       (clock),
        .rst         (rst),
        .p0_req      (p0_req),
        .p0_we       (p0_we),
        .p0_addr     (p0_addr),
        .p0_wdata    (p0_wdata),
        .p0_gnt      (p0_gnt),
        .p0_rvalid   (p0_rvalid),
        .p0_rdata    (p0_rdata),
        .p1_req      (p1_req),
        .p1_we       (p1_we),
        .p1_addr     (p1_addr),
        .p1_wdata    (p1_wdata),
        .p1_gnt      (p1_gnt),
        .p1_rvalid   (p1_rvalid),
        .p1_rdata    (p1_rdata),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_rden    (mem_rden),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
`ifdef DM_ARB_STATS_EN
        ,
        .p0_cnt      (p0_cnt),
        .p1_cnt      (p1_cnt),
        .conflict_cnt(conflict_cnt)
`endif
    );

    // Memory samples strobes on the falling edge, like the real data memory.
    always @(negedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        if (mem_rden) mem_q <= mem[mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic single(input bit port, input bit we, input logic [7:0] addr, input logic [31:0] wd);
        bit seen = 1'b0;
        if (!port) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
        end
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = port ? p1_gnt : p0_gnt;
        end
        chk("single_gnt", 32'(seen), 32'd1);
        if (!port) p0_req = 1'b0;
        else       p1_req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;

        // Reset held with both ports requesting
        rst = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'd1; p0_wdata = 32'h0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'd2; p1_wdata = 32'h0;
        tick();
        tick();
        chk("rst_p0_gnt",   32'(p0_gnt), 32'd0);
        chk("rst_p1_gnt",   32'(p1_gnt), 32'd0);
        chk("rst_rden",     32'(mem_rden), 32'd0);
        chk("rst_wren",     32'(mem_wren), 32'd0);
        chk("rst_p0_rv",    32'(p0_rvalid), 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);
        chk("rst_addr",     32'(mem_address), 32'd0);

        // First tie after reset goes to p0, the next tie to p1
        rst = 1'b1;
        tick();
        chk("first_p0_gnt", 32'(p0_gnt), 32'd1);
        chk("first_p1_gnt", 32'(p1_gnt), 32'd0);
        chk("first_rden",   32'(mem_rden), 32'd1);
        chk("first_addr",   32'(mem_address), 32'd1);
        p0_addr = 8'd3;
        tick();
        chk("first_rv",     32'(p0_rvalid), 32'd1);
        chk("first_rdata",  p0_rdata, 32'h1000_0001);
        chk("first_gnt_lo", 32'(p0_gnt | p1_gnt), 32'd0);
        tick();
        chk("tie2_p1_gnt",  32'(p1_gnt), 32'd1);
        chk("tie2_p0_gnt",  32'(p0_gnt), 32'd0);
        chk("tie2_addr",    32'(mem_address), 32'd2);
        p1_req = 1'b0;
        tick();
        chk("tie2_rv",      32'(p1_rvalid), 32'd1);
        chk("tie2_rdata",   p1_rdata, 32'h1000_0002);
        tick();
        chk("p0b_gnt",      32'(p0_gnt), 32'd1);
        chk("p0b_addr",     32'(mem_address), 32'd3);
        p0_req = 1'b0;
        tick();
        chk("p0b_rdata",    p0_rdata, 32'h1000_0003);

        // Write then read back on port 0
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'd5; p0_wdata = 32'hDEAD_BEEF;
        tick();
        chk("wr_gnt",   32'(p0_gnt), 32'd1);
        chk("wr_wren",  32'(mem_wren), 32'd1);
        chk("wr_rden",  32'(mem_rden), 32'd0);
        chk("wr_data",  mem_data, 32'hDEAD_BEEF);
        p0_we = 1'b0;
        tick();
        chk("wr_wren_off", 32'(mem_wren), 32'd0);
        chk("wr_no_rv",    32'(p0_rvalid), 32'd0);
        chk("wr_rdata_keep", p0_rdata, 32'h1000_0003);
        tick();
        chk("rd_gnt",   32'(p0_gnt), 32'd1);
        chk("rd_rden",  32'(mem_rden), 32'd1);
        p0_req = 1'b0;
        tick();
        chk("rd_rv",    32'(p0_rvalid), 32'd1);
        chk("rd_rdata", p0_rdata, 32'hDEAD_BEEF);
        tick();
        chk("rd_rv_off", 32'(p0_rvalid), 32'd0);

        // Continuous contention: strict alternation
        single(1'b0, 1'b1, 8'd11, 32'hAAAA_0011);
        single(1'b1, 1'b1, 8'd22, 32'hBBBB_0022);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'd11;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'd22;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("alt_p0_gnt", 32'(p0_gnt),    32'(i % 4 == 0));
            chk("alt_p1_gnt", 32'(p1_gnt),    32'(i % 4 == 2));
            chk("alt_p0_rv",  32'(p0_rvalid), 32'(i % 4 == 1));
            chk("alt_p1_rv",  32'(p1_rvalid), 32'(i % 4 == 3));
            if (i % 4 == 1) chk("alt_p0_rdata", p0_rdata, 32'hAAAA_0011);
            if (i % 4 == 3) chk("alt_p1_rdata", p1_rdata, 32'hBBBB_0022);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;

        // Reset in the middle of a read access
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'd22;
        tick();
        chk("ra_gnt",  32'(p1_gnt), 32'd1);
        chk("ra_rden", 32'(mem_rden), 32'd1);
        rst = 1'b0;
        #1;
        chk("ra_rden_drop", 32'(mem_rden), 32'd0);
        chk("ra_gnt_drop",  32'(p1_gnt), 32'd0);
        tick();
        chk("ra_no_rv",     32'(p1_rvalid), 32'd0);
        chk("ra_rdata_clr", p1_rdata, 32'd0);
        rst = 1'b1;
        tick();
        chk("ra_regnt",     32'(p1_gnt), 32'd1);
        chk("ra_addr",      32'(mem_address), 32'd22);
        p1_req = 1'b0;
        tick();
        chk("ra_rv",        32'(p1_rvalid), 32'd1);
        chk("ra_rdata",     p1_rdata, 32'hBBBB_0022);

`ifdef DM_ARB_STATS_EN
        p0_req = 1'b1; p0_addr = 8'd11;
        p1_req = 1'b1; p1_addr = 8'd22;
        for (int i = 0; i < 19; i++) tick();
        p0_req = 1'b0;
        p1_req = 1'b0;
        for (int i = 0; i < 3; i++) single(1'b0, 1'b0, 8'(30 + i), 32'h0);
        chk("conflict_cnt", 32'(conflict_cnt), 32'd10);
        chk("p0_cnt",       32'(p0_cnt), 32'd8);
        chk("p1_cnt",       32'(p1_cnt), 32'd6);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
